// File: rtl/blockram_spool_ch.sv
// blockram_spool_ch: 8-bit register-mapped CPU port spooling sequential byte reads/writes to one block-RAM port.
// Optional feature macro BRSPOOL_IRQ_EN: adds irq_o and makes a status read clear done/aborted.
module blockram_spool_ch #(
  parameter int ADDR_W  = 16,
  parameter int STEP    = 1,
  parameter int RAM_LAT = 1,
  parameter int LEN_W   = 16
) (
  input  logic              clk_i,
  input  logic              areset_i,
  output logic [ADDR_W-1:0] address_o,
  output logic [7:0]        data_o,
  input  logic [7:0]        q_i,
  output logic              wren_o,
  input  logic [3:0]        A_i,
  input  logic [7:0]        D_i,
  output logic [7:0]        D_o,
  input  logic              rd_i,
  input  logic              wr_i
`ifdef BRSPOOL_IRQ_EN
  ,
  output logic              irq_o
`endif
);

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_RD_FETCH = 3'd1,
    S_RD_READY = 3'd2,
    S_WR_READY = 3'd3,
    S_WR_PULSE = 3'd4
  } state_t;

  state_t              r_state;
  state_t              w_next;

  logic [ADDR_W-1:0]   r_start;
  logic [LEN_W-1:0]    r_len;
  logic [LEN_W-1:0]    r_cnt;
  logic [2:0]          r_lat;
  logic [7:0]          r_rd_buf;
  logic                r_done;
  logic                r_aborted;
`ifdef BRSPOOL_IRQ_EN
  logic                r_irq;
`endif

  logic [15:0]         w_start16;
  logic [15:0]         w_len16;
  logic [15:0]         w_addr16;
  logic [7:0]          w_status;
  logic [7:0]          w_rd_val;
  logic                w_busy;
  logic                w_reg_wr;
  logic                w_cmd_wr;
  logic                w_abort;
  logic                w_start_rd;
  logic                w_start_wr;
  logic                w_rd_data;
  logic                w_wr_data;
  logic                w_lat_hit;
  logic                w_last;
  logic                w_set_done;

  assign w_start16  = 16'(r_start);
  assign w_len16    = 16'(r_len);
  assign w_addr16   = 16'(address_o);
  assign w_busy     = (r_state != S_IDLE);
  assign w_status   = {w_busy, (r_state == S_RD_READY), (r_state == S_WR_READY),
                       r_aborted, r_done, 3'b000};

  assign w_reg_wr   = wr_i && !w_busy;
  assign w_cmd_wr   = wr_i && (A_i == 4'd15);
  // Abort beats any start bit carried in the same command byte.
  assign w_abort    = w_cmd_wr && D_i[7];
  assign w_start_rd = w_cmd_wr && !D_i[7] && D_i[0] && !w_busy;
  assign w_start_wr = w_cmd_wr && !D_i[7] && !D_i[0] && D_i[1] && !w_busy;
  assign w_rd_data  = rd_i && (A_i == 4'd8) && (r_state == S_RD_READY);
  assign w_wr_data  = wr_i && (A_i == 4'd8) && (r_state == S_WR_READY);
  assign w_lat_hit  = (r_state == S_RD_FETCH) && (r_lat == 3'(RAM_LAT - 1));
  // A zero length loads cnt=0, which never reaches 1, so the transfer never completes.
  assign w_last     = (r_cnt == LEN_W'(1));
  assign w_set_done = !w_abort && w_last &&
                      (((r_state == S_RD_READY) && w_rd_data) || (r_state == S_WR_PULSE));

  always_comb begin
    w_rd_val = 8'h00;
    case (A_i)
      4'd0:    w_rd_val = w_start16[7:0];
      4'd1:    w_rd_val = w_start16[15:8];
      4'd4:    w_rd_val = w_len16[7:0];
      4'd5:    w_rd_val = w_len16[15:8];
      4'd8:    w_rd_val = r_rd_buf;
      4'd12:   w_rd_val = w_addr16[7:0];
      4'd13:   w_rd_val = w_addr16[15:8];
      4'd14:   w_rd_val = w_status;
      default: w_rd_val = 8'h00;
    endcase
  end

  always_comb begin
    w_next = r_state;
    if (w_abort) begin
      w_next = S_IDLE;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_start_rd)      w_next = S_RD_FETCH;
          else if (w_start_wr) w_next = S_WR_READY;
        end
        S_RD_FETCH: if (w_lat_hit) w_next = S_RD_READY;
        S_RD_READY: if (w_rd_data) w_next = w_last ? S_IDLE : S_RD_FETCH;
        S_WR_READY: if (w_wr_data) w_next = S_WR_PULSE;
        S_WR_PULSE: w_next = w_last ? S_IDLE : S_WR_READY;
        default:    w_next = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk_i or posedge areset_i) begin
    if (areset_i) r_state <= S_IDLE;
    else          r_state <= w_next;
  end

  always_ff @(posedge clk_i or posedge areset_i) begin
    if (areset_i) begin
      address_o <= '0;
      data_o    <= 8'h00;
      wren_o    <= 1'b0;
      D_o       <= 8'h00;
      r_start   <= '0;
      r_len     <= '0;
      r_cnt     <= '0;
      r_lat     <= 3'd0;
      r_rd_buf  <= 8'h00;
      r_done    <= 1'b0;
      r_aborted <= 1'b0;
`ifdef BRSPOOL_IRQ_EN
      r_irq     <= 1'b0;
`endif
    end else begin
      if (rd_i) D_o <= w_rd_val;

      if (w_reg_wr) begin
        case (A_i)
          4'd0:    r_start <= ADDR_W'({w_start16[15:8], D_i});
          4'd1:    r_start <= ADDR_W'({D_i, w_start16[7:0]});
          4'd4:    r_len   <= LEN_W'({w_len16[15:8], D_i});
          4'd5:    r_len   <= LEN_W'({D_i, w_len16[7:0]});
          default: ;
        endcase
      end

`ifdef BRSPOOL_IRQ_EN
      // Clear-on-read; a flag set in the same cycle wins via the later assignments.
      if (rd_i && (A_i == 4'd14)) begin
        r_done    <= 1'b0;
        r_aborted <= 1'b0;
      end
      r_irq <= w_abort | w_set_done;
`endif

      if (w_abort) begin
        wren_o    <= 1'b0;
        r_aborted <= 1'b1;
      end else begin
        case (r_state)
          S_IDLE: begin
            if (w_start_rd || w_start_wr) begin
              address_o <= r_start;
              r_cnt     <= r_len;
              r_lat     <= 3'd0;
              r_done    <= 1'b0;
              r_aborted <= 1'b0;
            end
          end
          S_RD_FETCH: begin
            if (w_lat_hit) begin
              r_rd_buf  <= q_i;
              address_o <= address_o + ADDR_W'(STEP);
            end else begin
              r_lat <= r_lat + 3'd1;
            end
          end
          S_RD_READY: begin
            if (w_rd_data) begin
              r_lat <= 3'd0;
              if (r_cnt != '0) r_cnt <= r_cnt - LEN_W'(1);
              if (w_set_done)  r_done <= 1'b1;
            end
          end
          S_WR_READY: begin
            if (w_wr_data) begin
              data_o <= D_i;
              wren_o <= 1'b1;
            end
          end
          S_WR_PULSE: begin
            wren_o    <= 1'b0;
            address_o <= address_o + ADDR_W'(STEP);
            if (r_cnt != '0) r_cnt <= r_cnt - LEN_W'(1);
            if (w_set_done)  r_done <= 1'b1;
          end
          default: ;
        endcase
      end
    end
  end

`ifdef BRSPOOL_IRQ_EN
  assign irq_o = r_irq;
`endif

endmodule

// File: tb/tb_blockram_spool_ch.sv
// Directed bench for blockram_spool_ch: two instances (default, and STEP=4/RAM_LAT=2) with
// behavioural RAM models and queue scoreboards for read bytes and RAM write events.
module tb_blockram_spool_ch;

  logic        clk = 1'b0;
  logic        areset = 1'b1;
  logic [3:0]  A = 4'd0;
  logic [7:0]  D = 8'h00;
  logic        rd = 1'b0;
  logic        wr = 1'b0;
  logic        sel = 1'b0;

  logic [15:0] addr0, addr1, addr1_d;
  logic [7:0]  data0, data1, q0, q1, Do0, Do1;
  logic        wren0, wren1;
  logic        rd0, wr0, rd1, wr1;
`ifdef BRSPOOL_IRQ_EN
  logic        irq0, irq1;
`endif

  always #5 clk = ~clk;

  assign rd0 = rd && !sel;
  assign wr0 = wr && !sel;
  assign rd1 = rd && sel;
  assign wr1 = wr && sel;

  // RAM models: u0 sees data combinationally (latency 1), u1 through one extra address register (latency 2).
  assign q0 = addr0[7:0];
  always @(posedge clk) addr1_d <= addr1;
  assign q1 = addr1_d[7:0];

  blockram_spool_ch u0 (
    .clk_i(clk), .areset_i(areset), .address_o(addr0), .data_o(data0), .q_i(q0),
    .wren_o(wren0), .A_i(A), .D_i(D), .D_o(Do0), .rd_i(rd0), .wr_i(wr0)
`ifdef BRSPOOL_IRQ_EN
    , .irq_o(irq0)
`endif
  );

  blockram_spool_ch #(.ADDR_W(16), .STEP(4), .RAM_LAT(2), .LEN_W(16)) u1 (
    .clk_i(clk), .areset_i(areset), .address_o(addr1), .data_o(data1), .q_i(q1),
    .wren_o(wren1), .A_i(A), .D_i(D), .D_o(Do1), .rd_i(rd1), .wr_i(wr1)
`ifdef BRSPOOL_IRQ_EN
    , .irq_o(irq1)
`endif
  );

  typedef struct { logic [15:0] a; logic [7:0] d; } wr_ev_t;
  wr_ev_t     wq[$];
  logic [7:0] rq[$];
  int         n_vec = 0;
  int         n_err = 0;
  logic       prev_w = 1'b0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic cpu_wr(input logic [3:0] a, input logic [7:0] d);
    @(negedge clk);
    A = a; D = d; wr = 1'b1;
    @(negedge clk);
    wr = 1'b0;
  endtask

  task automatic cpu_rd(input logic [3:0] a, output logic [7:0] v);
    @(negedge clk);
    A = a; rd = 1'b1;
    @(negedge clk);
    rd = 1'b0;
    v = sel ? Do1 : Do0;
  endtask

  task automatic rd_chk(input string tag, input logic [3:0] a, input logic [7:0] exp);
    logic [7:0] v;
    cpu_rd(a, v);
    check(tag, v, exp);
  endtask

  task automatic rd8(input string tag);
    logic [7:0]  v;
    logic [31:0] e;
    cpu_rd(4'd8, v);
    e = (rq.size() != 0) ? 32'(rq.pop_front()) : 32'h100;
    check(tag, v, e);
  endtask

  task automatic wait_flag(input int bitn, input string tag);
    logic [7:0] s;
    int k;
    k = 0;
    do begin
      cpu_rd(4'd14, s);
      k++;
    end while (!s[bitn] && k < 40);
    check(tag, s[bitn], 1);
  endtask

  task automatic setup(input logic [15:0] a, input logic [15:0] l);
    cpu_wr(4'd0, a[7:0]);
    cpu_wr(4'd1, a[15:8]);
    cpu_wr(4'd4, l[7:0]);
    cpu_wr(4'd5, l[15:8]);
  endtask

  // Write monitor: every wren pulse must be single-cycle and match the next expected event.
  always @(negedge clk) begin
    wr_ev_t w;
    if (wren0) begin
      check("wren width", prev_w, 0);
      if (wq.size() != 0) w = wq.pop_front();
      else w = '{a: 16'hxxxx, d: 8'hxx};
      check("write addr", addr0, w.a);
      check("write data", data0, w.d);
    end
    if (wren1) check("u1 wren", wren1, 0);
    prev_w = wren0;
  end

  initial begin
    #200000;
    $display("FAIL timeout vectors=%0d", n_vec);
    $fatal(1, "timeout");
  end

  initial begin
    repeat (3) @(negedge clk);
    check("rst addr", addr0, 16'h0000);
    check("rst data", data0, 8'h00);
    check("rst wren", wren0, 0);
    check("rst D_o", Do0, 8'h00);
    check("rst u1 addr", addr1, 16'h0000);
    areset = 1'b0;
    rd_chk("rst status", 4'd14, 8'h00);

    // Read of three bytes from 0x0100
    setup(16'h0100, 16'd3);
    rq.push_back(8'h00); rq.push_back(8'h01); rq.push_back(8'h02);
    cpu_wr(4'd15, 8'h01);
    for (int i = 0; i < 3; i++) begin
      wait_flag(6, "t1 rd_rdy");
      rd8("t1 byte");
    end
    rd_chk("t1 status", 4'd14, 8'h08);
    rd_chk("t1 live lo", 4'd12, 8'h03);
    rd_chk("t1 live hi", 4'd13, 8'h01);
    rd_chk("t1 idle reg8", 4'd8, 8'h02);

    // Write of two bytes at 0x0010
    setup(16'h0010, 16'd2);
    wq.push_back('{a: 16'h0010, d: 8'hAA});
    wq.push_back('{a: 16'h0011, d: 8'h55});
    cpu_wr(4'd15, 8'h02);
    cpu_wr(4'd8, 8'hAA);
    cpu_wr(4'd8, 8'h55);
    rd_chk("t2 status", 4'd14, 8'h08);
    check("t2 writes left", wq.size(), 0);

    // Address wrap at 0xFFFF
    setup(16'hFFFF, 16'd2);
    rq.push_back(8'hFF); rq.push_back(8'h00);
    cpu_wr(4'd15, 8'h01);
    for (int i = 0; i < 2; i++) begin
      wait_flag(6, "t3 rd_rdy");
      rd8("t3 byte");
    end
    rd_chk("t3 live lo", 4'd12, 8'h01);
    rd_chk("t3 live hi", 4'd13, 8'h00);

    // Abort together with start, then start while busy
    cpu_wr(4'd15, 8'h83);
    rd_chk("t5 abort+start status", 4'd14, 8'h18);
    rd_chk("t5 addr kept", 4'd12, 8'h01);
    setup(16'h0200, 16'd2);
    rq.push_back(8'h00); rq.push_back(8'h01);
    cpu_wr(4'd15, 8'h01);
    wait_flag(6, "t5 rd_rdy a");
    rd8("t5 byte0");
    wait_flag(6, "t5 rd_rdy b");
    cpu_wr(4'd15, 8'h01);
    cpu_wr(4'd15, 8'h02);
    cpu_wr(4'd0, 8'h77);
    rd_chk("t5 start lo locked", 4'd0, 8'h00);
    rd_chk("t5 live busy", 4'd12, 8'h02);
    rd_chk("t5 busy status", 4'd14, 8'hC0);
    rd8("t5 byte1");
    rd_chk("t5 done status", 4'd14, 8'h08);

    // Unlimited write of five bytes, then abort
    setup(16'h0040, 16'd0);
    for (int i = 0; i < 5; i++) wq.push_back('{a: 16'(16'h0040 + i), d: 8'(8'h10 + i)});
    cpu_wr(4'd15, 8'h02);
    rd_chk("t4 wr_rdy status", 4'd14, 8'hA0);
    for (int i = 0; i < 5; i++) cpu_wr(4'd8, 8'(8'h10 + i));
    cpu_wr(4'd15, 8'h80);
    rd_chk("t4 abort status", 4'd14, 8'h10);
    rd_chk("t4 live lo", 4'd12, 8'h45);
    cpu_wr(4'd8, 8'h77);
    repeat (2) @(negedge clk);
    check("t4 writes left", wq.size(), 0);

    // STEP=4, RAM_LAT=2 instance
    sel = 1'b1;
    setup(16'h0020, 16'd2);
    rq.push_back(8'h20); rq.push_back(8'h24);
    cpu_wr(4'd15, 8'h01);
    for (int i = 0; i < 2; i++) begin
      wait_flag(6, "t6 rd_rdy");
      rd8("t6 byte");
    end
    rd_chk("t6 live lo", 4'd12, 8'h28);
    rd_chk("t6 status", 4'd14, 8'h08);
    sel = 1'b0;

    // Asynchronous reset in the middle of an unlimited read
    setup(16'h0300, 16'd0);
    cpu_wr(4'd15, 8'h01);
    wait_flag(6, "t7 rd_rdy");
    @(negedge clk);
    #1 areset = 1'b1;
    #1;
    check("t7 async addr", addr0, 16'h0000);
    check("t7 async D_o", Do0, 8'h00);
    @(negedge clk);
    areset = 1'b0;
    rd_chk("t7 status", 4'd14, 8'h00);
    rd_chk("t7 start reg", 4'd1, 8'h00);

    check("read queue empty", rq.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
